// File: rtl/arb4to1b16_if.sv
// Producer/consumer bundle for the 4:1 round-robin arbiter.
// Ports: in_valid/in_data0..3/in_ready (four producers), out_valid/out_data/out_ready (consumer),
//        sel (index of the channel that supplied out_data). slave = arbiter side, master = environment side.
interface arb4to1b16_if #(parameter int W = 16);
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic [W-1:0] in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   sel;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, sel
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, sel
  );
endinterface

// File: rtl/arb4to1b16.sv
// Four-channel round-robin arbiter with a one-entry registered output stage.
// Latency: word granted at edge N is presented with out_valid=1 in cycle N+1; one word/cycle when out_ready stays high.
// Backpressure: while a held word is not taken (out_valid && !out_ready) no channel is granted; out_data/sel stay put.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the four producer handshakes,
//        the consumer handshake and sel, the registered select for the downstream 4:1 mux.
module arb4to1b16 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  arb4to1b16_if.slave  bus
);

  logic [1:0]   ptr;
  logic         held_valid;
  logic [W-1:0] held_data;
  logic [1:0]   held_sel;

  logic [1:0]   gnt;
  logic [1:0]   idx;
  logic         found;
  logic         load;
  logic [W-1:0] gnt_data;

  // Rotating priority search starting at ptr; the first requester found wins.
  always_comb begin
    gnt   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.in_valid[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_data = bus.in_data0;
    case (gnt)
      2'd0:    gnt_data = bus.in_data0;
      2'd1:    gnt_data = bus.in_data1;
      2'd2:    gnt_data = bus.in_data2;
      default: gnt_data = bus.in_data3;
    endcase
  end

  // Accept when the slot is empty or its word drains on this same edge.
  assign load = (|bus.in_valid) && (!held_valid || bus.out_ready);

  // Gated by rst so no producer believes it was accepted while reset discards state.
  assign bus.in_ready = (load && !rst) ? (4'b0001 << gnt) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 2'd0;
      held_valid <= 1'b0;
      held_data  <= '0;
      held_sel   <= 2'd0;
    end else if (load) begin
      ptr        <= gnt + 2'd1;
      held_valid <= 1'b1;
      held_data  <= gnt_data;
      held_sel   <= gnt;
    end else if (held_valid && bus.out_ready) begin
      // Drain only: data and sel keep their last values so the mux select stays coherent.
      held_valid <= 1'b0;
    end
  end

  assign bus.out_valid = held_valid;
  assign bus.out_data  = held_data;
  assign bus.sel       = held_sel;

endmodule
